// File: rtl/i2c_apb_cmd_sequencer.sv
// Converts single-byte EEPROM write/read commands into the APB register sequence of an I2C master.
// Define SEQ_POLL_TIMEOUT_EN to abort STATUS polling after POLL_MAX reads with rsp_err = 2'b11.
module i2c_apb_cmd_sequencer #(
  parameter logic [31:0] ADDR_SLV   = 32'h04,
  parameter logic [31:0] ADDR_WDATA = 32'h08,
  parameter logic [31:0] ADDR_CTRL  = 32'h00,
  parameter logic [31:0] ADDR_RDATA = 32'h0C,
  parameter logic [31:0] ADDR_STAT  = 32'h10,
  parameter int          POLL_GAP   = 8,
  parameter int          POLL_MAX   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [7:0]  cmd_mem_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  output logic        apb_write,
  output logic        apb_sel,
  output logic        apb_enable,
  input  logic [31:0] apb_rdata,
  input  logic        apb_ready,
  input  logic        apb_slverr
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP, ST_RESP} state_t;
  typedef enum logic [2:0] {STEP_SLV, STEP_WDATA, STEP_CTRL, STEP_STAT, STEP_RDATA} step_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_SLV  = 2'b01;
  localparam logic [1:0] ERR_NACK = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  state_t     state, state_nxt;
  step_t      step, step_nxt;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] mem_q, wdata_q;
  logic [7:0] gap_cnt;
  logic [7:0] rsp_data_q, rsp_data_nxt;
  logic [1:0] rsp_err_q, rsp_err_nxt;
  logic       rsp_load;
  logic       accept, stat_xfer, poll_timeout;

  assign accept    = cmd_valid && cmd_ready;
  assign stat_xfer = (state == ST_ACCESS) && apb_ready && (step == STEP_STAT);

  // STATUS busy flag and upper read-data bits carry nothing this sequencer needs.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, apb_rdata[31:8], apb_rdata[0]};

`ifdef SEQ_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt, poll_cnt_inc;
  assign poll_cnt_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign poll_timeout = (poll_cnt_inc >= 16'(POLL_MAX));

  always_ff @(posedge clk) begin
    if (rst)            poll_cnt <= '0;
    else if (accept)    poll_cnt <= '0;
    else if (stat_xfer) poll_cnt <= poll_cnt_inc;
  end
`else
  assign poll_timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step       <= STEP_SLV;
      rw_q       <= 1'b0;
      dev_q      <= '0;
      mem_q      <= '0;
      wdata_q    <= '0;
      gap_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (accept) begin
        rw_q    <= cmd_rw;
        dev_q   <= cmd_dev_addr;
        mem_q   <= cmd_mem_addr;
        wdata_q <= cmd_wdata;
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_data_nxt;
        rsp_err_q  <= rsp_err_nxt;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    rsp_load     = 1'b0;
    rsp_data_nxt = 8'h00;
    rsp_err_nxt  = ERR_OK;
    unique case (state)
      ST_IDLE: if (cmd_valid) begin
        state_nxt = ST_SETUP;
        step_nxt  = STEP_SLV;
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb_ready) begin
        if (apb_slverr) begin
          state_nxt   = ST_RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = ERR_SLV;
        end else begin
          state_nxt = ST_SETUP;
          unique case (step)
            STEP_SLV:   step_nxt = rw_q ? STEP_CTRL : STEP_WDATA;
            STEP_WDATA: step_nxt = STEP_CTRL;
            STEP_CTRL:  step_nxt = STEP_STAT;
            STEP_STAT: begin
              if (apb_rdata[1]) begin
                if (apb_rdata[2]) begin
                  state_nxt   = ST_RESP;
                  rsp_load    = 1'b1;
                  rsp_err_nxt = ERR_NACK;
                end else if (rw_q) begin
                  step_nxt = STEP_RDATA;
                end else begin
                  state_nxt = ST_RESP;
                  rsp_load  = 1'b1;
                end
              end else if (poll_timeout) begin
                state_nxt   = ST_RESP;
                rsp_load    = 1'b1;
                rsp_err_nxt = ERR_TMO;
              end else begin
                state_nxt = ST_GAP;
              end
            end
            STEP_RDATA: begin
              state_nxt    = ST_RESP;
              rsp_load     = 1'b1;
              rsp_data_nxt = apb_rdata[7:0];
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_GAP:  if (gap_cnt == 8'(POLL_GAP - 1)) state_nxt = ST_SETUP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address, data and direction derive only from registered step/fields, so they hold through ACCESS.
  always_comb begin
    apb_addr  = '0;
    apb_wdata = '0;
    apb_write = 1'b0;
    if (apb_sel) begin
      unique case (step)
        STEP_SLV: begin
          apb_addr  = ADDR_SLV;
          apb_wdata = {17'b0, dev_q, mem_q};
          apb_write = 1'b1;
        end
        STEP_WDATA: begin
          apb_addr  = ADDR_WDATA;
          apb_wdata = {24'b0, wdata_q};
          apb_write = 1'b1;
        end
        STEP_CTRL: begin
          apb_addr  = ADDR_CTRL;
          apb_wdata = {30'b0, rw_q, 1'b1};
          apb_write = 1'b1;
        end
        STEP_STAT:  apb_addr = ADDR_STAT;
        STEP_RDATA: apb_addr = ADDR_RDATA;
        default:    apb_addr = '0;
      endcase
    end
  end

  assign apb_sel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign apb_enable = (state == ST_ACCESS);
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_i2c_apb_cmd_sequencer.sv
// Directed bench for i2c_apb_cmd_sequencer with a reactive APB slave model and transfer log.
`timescale 1ns/1ps
module tb_i2c_apb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [6:0]  cmd_dev_addr = '0;
  logic [7:0]  cmd_mem_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [31:0] apb_addr, apb_wdata;
  logic        apb_write, apb_sel, apb_enable;
  logic [31:0] apb_rdata = '0;
  logic        apb_ready = 1'b1;
  logic        apb_slverr = 1'b0;

  always #5 clk = ~clk;

  i2c_apb_cmd_sequencer #(.POLL_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_write(apb_write),
    .apb_sel(apb_sel), .apb_enable(apb_enable),
    .apb_rdata(apb_rdata), .apb_ready(apb_ready), .apb_slverr(apb_slverr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model configuration and observation log
  int          wait_states = 0;
  int          ws_cnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] stat_vals[4];
  int          n_stat = 1;
  int          stat_idx = 0;
  logic [31:0] rdata_val = '0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_write[$];
  int          log_cyc[$];
  logic [31:0] s_addr, s_wdata;
  logic        s_write;
  int          stab_viol = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic [7:0]  rsp_data_s;
  logic [1:0]  rsp_err_s;

  always @(negedge clk) begin
    if (apb_sel && !apb_enable) begin
      s_addr = apb_addr; s_wdata = apb_wdata; s_write = apb_write; ws_cnt = 0;
    end else if (apb_sel && (apb_addr !== s_addr || apb_wdata !== s_wdata || apb_write !== s_write)) begin
      stab_viol++;
    end
    apb_ready = 1'b1; apb_slverr = 1'b0; apb_rdata = '0;
    if (apb_sel && apb_enable) begin
      if (ws_cnt < wait_states) begin
        ws_cnt++;
        apb_ready = 1'b0;
      end else begin
        if (err_en && apb_addr == err_addr) apb_slverr = 1'b1;
        if (apb_addr == 32'h10) begin
          apb_rdata = stat_vals[stat_idx];
          if (stat_idx < n_stat - 1) stat_idx++;
        end else if (apb_addr == 32'h0C) begin
          apb_rdata = rdata_val;
        end
        log_addr.push_back(apb_addr);
        log_wdata.push_back(apb_wdata);
        log_write.push_back(apb_write);
        log_cyc.push_back(cyc);
      end
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_data_s = rsp_data;
      rsp_err_s = rsp_err;
    end
  end

  task automatic clear_slave();
    log_addr.delete(); log_wdata.delete(); log_write.delete(); log_cyc.delete();
    wait_states = 0; err_en = 1'b0; err_addr = '0; rdata_val = '0;
    for (int i = 0; i < 4; i++) stat_vals[i] = 32'h2;
    n_stat = 1; stat_idx = 0; stab_viol = 0;
  endtask

  task automatic issue_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] mem,
                           input logic [7:0] wd, input logic hold, output int acc);
    int n = 0;
    acc = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_wait: cmd_ready stayed %b, required 1 within 200 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = mem; cmd_wdata = wd;
    acc = cyc;
    @(negedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0; cmd_rw = ~rw; cmd_dev_addr = ~dev; cmd_mem_addr = ~mem; cmd_wdata = ~wd;
    end
  endtask

  task automatic wait_rsp(input int prev);
    int n = 0;
    while (rsp_cnt <= prev && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (rsp_cnt <= prev) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: no rsp_valid within 3000 cycles (count %0d)", rsp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (apb_sel !== 1'b0) begin n_bad++; $display("FAIL reset_apb_sel: got %b want 0", apb_sel); end
    n_cmp++; if (apb_enable !== 1'b0) begin n_bad++; $display("FAIL reset_apb_enable: got %b want 0", apb_enable); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({rsp_data, rsp_err} !== 10'h0) begin n_bad++; $display("FAIL reset_rsp: got %h/%b want 00/00", rsp_data, rsp_err); end
    n_cmp++; if ({apb_addr, apb_wdata, apb_write} !== 65'h0) begin n_bad++; $display("FAIL reset_apb_bus: got %h %h %b want zeros", apb_addr, apb_wdata, apb_write); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [31:0] ea[4]  = '{32'h04, 32'h08, 32'h00, 32'h10};
    logic [31:0] ewd[4] = '{32'h5012, 32'hA5, 32'h1, 32'h0};
    logic        ew[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    int acc, prev;
    clear_slave();
    prev = rsp_cnt;
    issue_cmd(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, acc);
    n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL write_busy: busy/cmd_ready got %b want 10", {busy, cmd_ready}); end
    wait_rsp(prev);
    n_cmp++; if (log_addr.size() !== 4) begin n_bad++; $display("FAIL write_xfer_count: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== ea[i] || log_write[i] !== ew[i]) begin
        n_bad++; $display("FAIL write_xfer%0d_addr: got %h/%b want %h/%b", i, log_addr[i], log_write[i], ea[i], ew[i]);
      end
      if (ew[i]) begin
        n_cmp++; if (log_wdata[i] !== ewd[i]) begin n_bad++; $display("FAIL write_xfer%0d_wdata: got %h want %h", i, log_wdata[i], ewd[i]); end
      end
    end
    n_cmp++; if (rsp_cyc - acc !== 9) begin n_bad++; $display("FAIL write_latency: got %0d want 9", rsp_cyc - acc); end
    n_cmp++; if ({rsp_data_s, rsp_err_s} !== 10'h0) begin n_bad++; $display("FAIL write_rsp: got %h/%b want 00/00", rsp_data_s, rsp_err_s); end
    @(negedge clk); #1;
    n_cmp++; if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin n_bad++; $display("FAIL write_after_rsp: busy/ready/valid got %b want 010", {busy, cmd_ready, rsp_valid}); end
  endtask

  task automatic test_read_poll();
    logic [31:0] ea[6] = '{32'h04, 32'h00, 32'h10, 32'h10, 32'h10, 32'h0C};
    int acc, prev;
    clear_slave();
    stat_vals[0] = 32'h1; stat_vals[1] = 32'h1; stat_vals[2] = 32'h2; n_stat = 3;
    rdata_val = 32'hFFFF_FF3C;
    prev = rsp_cnt;
    issue_cmd(1'b1, 7'h51, 8'h12, 8'h99, 1'b0, acc);
    wait_rsp(prev);
    n_cmp++; if (log_addr.size() !== 6) begin n_bad++; $display("FAIL read_xfer_count: got %0d want 6", log_addr.size()); end
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== ea[i]) begin n_bad++; $display("FAIL read_xfer%0d_addr: got %h want %h", i, log_addr[i], ea[i]); end
    end
    if (log_addr.size() >= 5) begin
      n_cmp++; if (log_wdata[0] !== 32'h5112) begin n_bad++; $display("FAIL read_slv_wdata: got %h want 00005112", log_wdata[0]); end
      n_cmp++; if (log_wdata[1] !== 32'h3) begin n_bad++; $display("FAIL read_ctrl_wdata: got %h want 00000003", log_wdata[1]); end
      n_cmp++; if (log_cyc[3] - log_cyc[2] !== 10) begin n_bad++; $display("FAIL read_poll_gap1: got %0d want 10", log_cyc[3] - log_cyc[2]); end
      n_cmp++; if (log_cyc[4] - log_cyc[3] !== 10) begin n_bad++; $display("FAIL read_poll_gap2: got %0d want 10", log_cyc[4] - log_cyc[3]); end
    end
    n_cmp++; if ({rsp_data_s, rsp_err_s} !== {8'h3C, 2'b00}) begin n_bad++; $display("FAIL read_rsp: got %h/%b want 3c/00", rsp_data_s, rsp_err_s); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b0, 8'h3C}) begin n_bad++; $display("FAIL read_rsp_hold: got %b/%h want 0/3c", rsp_valid, rsp_data); end
  endtask

  task automatic test_nack();
    int acc, prev;
    clear_slave();
    stat_vals[0] = 32'h6;
    rdata_val = 32'h77;
    prev = rsp_cnt;
    issue_cmd(1'b1, 7'h50, 8'h20, 8'h00, 1'b0, acc);
    wait_rsp(prev);
    n_cmp++; if (log_addr.size() !== 3) begin n_bad++; $display("FAIL nack_xfer_count: got %0d want 3", log_addr.size()); end
    n_cmp++; if ({rsp_data_s, rsp_err_s} !== {8'h00, 2'b10}) begin n_bad++; $display("FAIL nack_rsp: got %h/%b want 00/10", rsp_data_s, rsp_err_s); end
  endtask

  task automatic test_slverr();
    int acc, prev;
    clear_slave();
    err_en = 1'b1; err_addr = 32'h08;
    prev = rsp_cnt;
    issue_cmd(1'b0, 7'h50, 8'h30, 8'h5A, 1'b0, acc);
    wait_rsp(prev);
    n_cmp++; if (log_addr.size() !== 2) begin n_bad++; $display("FAIL slverr_xfer_count: got %0d want 2", log_addr.size()); end
    n_cmp++; if ({rsp_data_s, rsp_err_s} !== {8'h00, 2'b01}) begin n_bad++; $display("FAIL slverr_rsp: got %h/%b want 00/01", rsp_data_s, rsp_err_s); end
  endtask

  task automatic test_back_to_back();
    int acc, prev, r;
    clear_slave();
    wait_states = 2;
    prev = rsp_cnt;
    issue_cmd(1'b0, 7'h22, 8'h44, 8'h66, 1'b1, acc);
    wait_rsp(prev);
    r = rsp_cyc;
    n_cmp++; if (r - acc !== 17) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 17", r - acc); end
    @(negedge clk); #1;
    n_cmp++; if ({cmd_ready, apb_sel} !== 2'b10) begin n_bad++; $display("FAIL b2b_idle_after_resp: ready/sel got %b want 10", {cmd_ready, apb_sel}); end
    @(negedge clk); #1;
    n_cmp++; if ({apb_sel, apb_enable} !== 2'b10) begin n_bad++; $display("FAIL b2b_second_setup: sel/enable got %b want 10", {apb_sel, apb_enable}); end
    cmd_valid = 1'b0;
    prev = rsp_cnt;
    wait_rsp(prev);
    n_cmp++; if (rsp_cyc - (r + 1) !== 17) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 17", rsp_cyc - (r + 1)); end
    n_cmp++; if (log_addr.size() !== 8) begin n_bad++; $display("FAIL b2b_xfer_count: got %0d want 8", log_addr.size()); end
    n_cmp++; if (stab_viol !== 0) begin n_bad++; $display("FAIL b2b_bus_stable: %0d changes during ACCESS, want 0", stab_viol); end
    n_cmp++; if (rsp_err_s !== 2'b00) begin n_bad++; $display("FAIL b2b_rsp_err: got %b want 00", rsp_err_s); end
  endtask

`ifdef SEQ_POLL_TIMEOUT_EN
  task automatic test_timeout();
    int acc, prev, n_st;
    clear_slave();
    stat_vals[0] = 32'h1;
    prev = rsp_cnt;
    issue_cmd(1'b0, 7'h50, 8'h40, 8'h11, 1'b0, acc);
    wait_rsp(prev);
    n_st = 0;
    foreach (log_addr[i]) if (log_addr[i] == 32'h10) n_st++;
    n_cmp++; if (n_st !== 4) begin n_bad++; $display("FAIL timeout_stat_reads: got %0d want 4", n_st); end
    n_cmp++; if ({rsp_data_s, rsp_err_s} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL timeout_rsp: got %h/%b want 00/11", rsp_data_s, rsp_err_s); end
  endtask
`endif

  task automatic test_reset_mid_op();
    int acc, prev, rc, n;
    clear_slave();
    stat_vals[0] = 32'h1;
    issue_cmd(1'b1, 7'h50, 8'h12, 8'h00, 1'b0, acc);
    n = 0;
    while (!(apb_sel && apb_enable) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++; if ({apb_sel, apb_enable} !== 2'b11) begin n_bad++; $display("FAIL midrst_access_seen: sel/enable got %b want 11", {apb_sel, apb_enable}); end
    rc = rsp_cnt;
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({apb_sel, apb_enable, cmd_ready} !== 3'b001) begin n_bad++; $display("FAIL midrst_abandon: sel/enable/ready got %b want 001", {apb_sel, apb_enable, cmd_ready}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (rsp_cnt !== rc) begin n_bad++; $display("FAIL midrst_no_rsp: rsp count got %0d want %0d", rsp_cnt, rc); end
    clear_slave();
    prev = rsp_cnt;
    issue_cmd(1'b0, 7'h50, 8'h55, 8'hC3, 1'b0, acc);
    wait_rsp(prev);
    n_cmp++; if (log_addr.size() !== 4) begin n_bad++; $display("FAIL midrst_next_xfers: got %0d want 4", log_addr.size()); end
    n_cmp++; if (rsp_cyc - acc !== 9 || rsp_err_s !== 2'b00) begin n_bad++; $display("FAIL midrst_next_rsp: latency %0d err %b want 9/00", rsp_cyc - acc, rsp_err_s); end
  endtask

  initial begin
    clear_slave();
    test_reset();
    test_write();
    test_read_poll();
    test_nack();
    test_slverr();
    test_back_to_back();
`ifdef SEQ_POLL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
